serial_bank_mapper: RTL

SERIAL_BANK_MAPPER -- requirements
Module: serial_bank_mapper

---
 rtl/serial_bank_mapper.sv | 133 +++++++++++++
 1 files changed

// File: rtl/serial_bank_mapper.sv
// Serial-load bank mapper: a 5-bit serial port loads control, CHR and PRG bank
// registers, which map CPU/PPU addresses onto linear PRG ROM/RAM and CHR space.
module serial_bank_mapper #(
    parameter int         PRG_BANK_W   = 4,
    parameter bit         OUTER_PRG_EN = 1'b1,
    parameter bit         MMC1A        = 1'b0,
    parameter logic [6:0] PRG_RAM_BASE = 7'b1111000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        ce,
    input  logic [15:0] prg_ain,
    input  logic        prg_write,
    input  logic [7:0]  prg_din,
    input  logic [13:0] chr_ain,
    output logic [21:0] prg_aout,
    output logic        prg_allow,
    output logic [21:0] chr_aout,
    output logic        vram_a10,
    output logic        vram_ce,
    output logic        wram_en,
    output logic        load_done
);

    logic [4:0] shift_q, shift_d;
    logic [4:0] control_q, control_d;
    logic [4:0] chr0_q, chr0_d;
    logic [4:0] chr1_q, chr1_d;
    logic [4:0] prgb_q, prgb_d;
    logic       delay_q, delay_d;
    logic       load_done_q, load_done_d;

    logic       accept;
    logic [4:0] load_val;
    logic       unused_din;

    assign accept     = ce && prg_write && prg_ain[15] && !delay_q;
    assign load_val   = {prg_din[0], shift_q[4:1]};
    assign unused_din = ^prg_din[6:1];

    // The marker bit reaching shift[0] means four bits are already held.
    always_comb begin
        shift_d     = shift_q;
        control_d   = control_q;
        chr0_d      = chr0_q;
        chr1_d      = chr1_q;
        prgb_d      = prgb_q;
        delay_d     = delay_q;
        load_done_d = 1'b0;
        if (ce) begin
            if (accept)
                delay_d = 1'b1;
            else if (!prg_write)
                delay_d = 1'b0;
        end
        if (accept) begin
            if (prg_din[7]) begin
                shift_d   = 5'b10000;
                control_d = control_q | 5'b01100;
            end else if (!shift_q[0]) begin
                shift_d = load_val;
            end else begin
                case (prg_ain[14:13])
                    2'd0:    control_d = load_val;
                    2'd1:    chr0_d    = load_val;
                    2'd2:    chr1_d    = load_val;
                    default: prgb_d    = load_val;
                endcase
                shift_d     = 5'b10000;
                load_done_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            shift_q     <= 5'b10000;
            control_q   <= 5'b01100;
            chr0_q      <= 5'b00000;
            chr1_q      <= 5'b00000;
            prgb_q      <= 5'b00000;
            delay_q     <= 1'b0;
            load_done_q <= 1'b0;
        end else begin
            shift_q     <= shift_d;
            control_q   <= control_d;
            chr0_q      <= chr0_d;
            chr1_q      <= chr1_d;
            prgb_q      <= prgb_d;
            delay_q     <= delay_d;
            load_done_q <= load_done_d;
        end
    end

    logic [4:0]            chrsel;
    logic [PRG_BANK_W-1:0] prgsel;
    logic                  outer;
    logic                  ram_sel;
    logic [21:0]           rom_addr;

    always_comb begin
        if (!control_q[4])
            chrsel = {chr0_q[4:1], chr_ain[12]};
        else
            chrsel = chr_ain[12] ? chr1_q : chr0_q;

        case (control_q[3:2])
            2'b10:   prgsel = prg_ain[14] ? prgb_q[PRG_BANK_W-1:0] : '0;
            2'b11:   prgsel = prg_ain[14] ? '1 : prgb_q[PRG_BANK_W-1:0];
            default: prgsel = {prgb_q[PRG_BANK_W-1:1], prg_ain[14]};
        endcase

        outer    = OUTER_PRG_EN ? chrsel[4] : 1'b0;
        rom_addr = '0;
        rom_addr[PRG_BANK_W+14:0] = {outer, prgsel, prg_ain[13:0]};

        case (control_q[1:0])
            2'd0:    vram_a10 = 1'b0;
            2'd1:    vram_a10 = 1'b1;
            2'd2:    vram_a10 = chr_ain[10];
            default: vram_a10 = chr_ain[11];
        endcase
    end

    assign ram_sel   = (prg_ain[15:13] == 3'b011);
    assign wram_en   = MMC1A ? 1'b1 : ~prgb_q[4];
    assign prg_aout  = ram_sel ? {PRG_RAM_BASE, 2'b00, prg_ain[12:0]} : rom_addr;
    assign prg_allow = (prg_ain[15] && !prg_write) || (ram_sel && wram_en);
    assign chr_aout  = {5'b10000, chrsel, chr_ain[11:0]};
    assign vram_ce   = chr_ain[13];
    assign load_done = load_done_q;

endmodule
